xbar_forward_arbiter: RTL and testbench
=======================================

XBAR_FORWARD_ARBITER -- requirements
Module: xbar_forward_arbiter

Interface
REQ-001 Parameter masters, default 2: number of master interfaces competing for this slave.
REQ-002 Parameter slaves, default 2: number of slave ports; sets the destination-field width.
REQ-003 Parameter i_am_slave_number, default 0: index of the slave port this arbiter serves.
REQ-004 ACLK  input  1  clock; all state updates on its rising edge.
REQ-005 ARESETn  input  1  reset, synchronous, active-low.
REQ-006 master_fifo_empty  input  1 x [0:masters-1]  per-master forward FIFO empty, already gated by ID and write-lock blocking.
REQ-007 master_dest_slave  input  $clog2(slaves) x [0:masters-1]  decoded destination slave of each master's front entry.
REQ-008 slave_fifo_full  input  1  this slave's forward FIFO is full.
REQ-009 grant_master_number  output  $clog2(masters)+1  granted master index; NO_GRANT (all ones) when no grant is active.
REQ-010 push_to_fifo  output  1  grant is valid this cycle; the granted master pops, and the slave pushes, when this is high and slave_fifo_full is low.

Function
REQ-011 Request: req[i] = ~master_fifo_empty[i] & (master_dest_slave[i] == i_am_slave_number).
REQ-012 FSM has two states, IDLE and GRANT, and a registered grant index g and round-robin pointer rr_ptr.
REQ-013 IDLE: grant_master_number = NO_GRANT and push_to_fifo = 0.
REQ-014 IDLE with any req: latch the winner into g and enter GRANT next cycle. The winner is the first requester searching rr_ptr+1, rr_ptr+2, ... modulo masters.
REQ-015 GRANT: grant_master_number = g (zero-extended), and push_to_fifo = req[g] combinationally.
REQ-016 Transfer occurs when the state is GRANT & req[g] & ~slave_fifo_full; exactly one entry moves per transfer.
REQ-017 On transfer: rr_ptr <= g. If any req other than req[g] is asserted, g <= next winner searched from g+1 and the FSM stays in GRANT. Otherwise the FSM returns to IDLE.
REQ-018 Back-to-back transfers to different masters therefore sustain 1 entry/cycle. The same master may win again only after a one-cycle IDLE bubble.
REQ-019 GRANT & req[g] & slave_fifo_full: g, rr_ptr and state hold unchanged. The grant is never reprioritised while stalled on full.
REQ-020 GRANT & ~req[g] (requester withdrew or was ID-blocked): return to IDLE, rr_ptr unchanged, and no transfer.
REQ-021 rr_ptr wraps from masters-1 to 0. All index arithmetic is modulo masters and never yields NO_GRANT.
REQ-022 Simultaneous requests in IDLE resolve strictly by round-robin order, giving no master fixed priority.
REQ-023 Fairness: a continuously requesting master is granted within masters grant cycles, excluding cycles stalled on full.

Reset
REQ-024 ARESETn low at a clock edge: state = IDLE, g = 0, rr_ptr = masters-1 (master 0 wins first), and the outputs read NO_GRANT and 0 the following cycle.
REQ-025 Reset asserted mid-GRANT abandons the grant with no transfer counted. The first post-reset arbitration starts from master 0.

Structure
REQ-026 The NO_GRANT constant, the IDLE/GRANT state enum and the round-robin search function belong in shared package xbar_pkg.
REQ-027 The round-robin search is sub-module rr_pick: a combinational picker with inputs request vector and start index, and outputs valid and winner index.
REQ-028 One instance each is used per slave for AR and for AW. The R and B return paths keep their existing arbiter.

Verification
REQ-029 masters=2: both masters request slave 0 continuously with full=0 -> grants alternate 0,1,0,1, with push_to_fifo high every cycle after the first grant.
REQ-030 Master 1 requests slave 0 and full is held high for 3 cycles -> grant_master_number stays 1 and push_to_fifo stays 1 throughout; the transfer happens on the first cycle full=0.
REQ-031 Master 0 requests dest=1 while this arbiter has i_am_slave_number=0 -> grant stays NO_GRANT (3) and push_to_fifo stays 0.
REQ-032 Master 0 is granted, then master_fifo_empty[0] rises before the transfer -> IDLE next cycle, with NO_GRANT and rr_ptr unchanged.
REQ-033 masters=4: masters 0, 2 and 3 request with rr_ptr=2 -> grant order is 3,0,2.
REQ-034 ARESETn is pulsed low during GRANT of master 1 -> the next cycle shows NO_GRANT; with both masters requesting afterwards, master 0 is granted first.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar forward-path arbiters: grant sentinel, FSM states and
// the round-robin search used by every per-slave picker.
package xbar_pkg;

  localparam int unsigned MaxMasters = 32;
  localparam int unsigned PickW      = 5;

  // All ones; each arbiter truncates to its own grant width.
  localparam logic [31:0] NO_GRANT = '1;

  typedef enum logic {StIdle, StGrant} arb_state_e;

  typedef struct packed {
    logic             valid;
    logic [PickW-1:0] idx;
  } pick_t;

  // First set bit of req at or after start, wrapping modulo n.
  function automatic pick_t rr_search(input logic [MaxMasters-1:0] req,
                                      input logic [PickW-1:0]      start,
                                      input int unsigned           n);
    pick_t            p;
    int unsigned      idx;
    logic [PickW-1:0] sel;
    p = '0;
    for (int unsigned k = 0; k < MaxMasters; k++) begin
      idx = 32'(start) + k;
      if (idx >= n) idx = idx - n;
      sel = idx[PickW-1:0];
      if (k < n && !p.valid && req[sel]) begin
        p.valid = 1'b1;
        p.idx   = sel;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after the start index, wrapping.
module rr_pick
  import xbar_pkg::*;
#(
  parameter int unsigned masters = 2,
  localparam int unsigned IdxW   = masters > 1 ? $clog2(masters) : 1
) (
  input  logic [masters-1:0] req,
  input  logic [IdxW-1:0]    start,
  output logic               valid,
  output logic [IdxW-1:0]    winner
);

  pick_t pick;

  always_comb begin
    pick = rr_search(MaxMasters'(req), PickW'(start), masters);
  end

  assign valid  = pick.valid;
  assign winner = IdxW'(pick.idx);

endmodule

// File: rtl/xbar_forward_arbiter.sv
// Per-slave forward arbiter: round-robin grant among masters whose front entry targets this
// slave, sustaining one transfer per cycle when ownership rotates between masters.
module xbar_forward_arbiter
  import xbar_pkg::*;
#(
  parameter int unsigned masters           = 2,
  parameter int unsigned slaves            = 2,
  parameter int unsigned i_am_slave_number = 0,
  localparam int unsigned IdxW   = masters > 1 ? $clog2(masters) : 1,
  localparam int unsigned GrantW = $clog2(masters) + 1,
  localparam int unsigned DestW  = slaves > 1 ? $clog2(slaves) : 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              master_fifo_empty [0:masters-1],
  input  logic [DestW-1:0]  master_dest_slave [0:masters-1],
  input  logic              slave_fifo_full,
  output logic [GrantW-1:0] grant_master_number,
  output logic              push_to_fifo
);

  arb_state_e        state;
  logic [IdxW-1:0]   g;
  logic [IdxW-1:0]   rr_ptr;
  logic [masters-1:0] req;
  logic [masters-1:0] pick_req;
  logic [IdxW-1:0]   pick_start;
  logic [IdxW-1:0]   pick_winner;
  logic              pick_valid;

  function automatic logic [IdxW-1:0] inc(input logic [IdxW-1:0] x);
    return (32'(x) == masters - 1) ? '0 : x + IdxW'(1);
  endfunction

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < masters; i++) begin
      req[i] = ~master_fifo_empty[i] & (master_dest_slave[i] == DestW'(i_am_slave_number));
    end
  end

  // While granted, the picker looks for a different master to hand over to without a bubble;
  // masking g means the current owner must drop back through idle to win again.
  always_comb begin
    pick_req   = req;
    pick_start = inc(rr_ptr);
    if (state == StGrant) begin
      pick_req[g] = 1'b0;
      pick_start  = inc(g);
    end
  end

  rr_pick #(
    .masters(masters)
  ) u_pick (
    .req   (pick_req),
    .start (pick_start),
    .valid (pick_valid),
    .winner(pick_winner)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state  <= StIdle;
      g      <= '0;
      rr_ptr <= IdxW'(masters - 1);
    end else begin
      case (state)
        StIdle: begin
          if (pick_valid) begin
            g     <= pick_winner;
            state <= StGrant;
          end
        end
        StGrant: begin
          if (req[g]) begin
            // Stalled on full: hold everything so the grant is never reprioritised.
            if (!slave_fifo_full) begin
              rr_ptr <= g;
              if (pick_valid) g <= pick_winner;
              else            state <= StIdle;
            end
          end else begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign grant_master_number = (state == StGrant) ? GrantW'(g) : GrantW'(NO_GRANT);
  assign push_to_fifo        = (state == StGrant) & req[g];

endmodule

// File: tb/tb_xbar_forward_arbiter.sv
// Directed bench: a 2-master and a 4-master arbiter driven through hand-traced cycle sequences.
module tb_xbar_forward_arbiter;

  logic       aclk;
  logic       rst_n;
  logic       empty_a [0:1];
  logic [0:0] dest_a  [0:1];
  logic       full_a;
  logic [1:0] gnt_a;
  logic       push_a;
  logic       empty_b [0:3];
  logic [0:0] dest_b  [0:3];
  logic       full_b;
  logic [2:0] gnt_b;
  logic       push_b;

  int errors;
  int checks;

  xbar_forward_arbiter #(
    .masters(2),
    .slaves(2),
    .i_am_slave_number(0)
  ) dut_a (
    .ACLK               (aclk),
    .ARESETn            (rst_n),
    .master_fifo_empty  (empty_a),
    .master_dest_slave  (dest_a),
    .slave_fifo_full    (full_a),
    .grant_master_number(gnt_a),
    .push_to_fifo       (push_a)
  );

  xbar_forward_arbiter #(
    .masters(4),
    .slaves(2),
    .i_am_slave_number(0)
  ) dut_b (
    .ACLK               (aclk),
    .ARESETn            (rst_n),
    .master_fifo_empty  (empty_b),
    .master_dest_slave  (dest_b),
    .slave_fifo_full    (full_b),
    .grant_master_number(gnt_b),
    .push_to_fifo       (push_b)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    empty_a = '{1'b1, 1'b1};
    dest_a  = '{1'b0, 1'b0};
    full_a  = 1'b0;
    empty_b = '{1'b1, 1'b1, 1'b1, 1'b1};
    dest_b  = '{1'b0, 1'b0, 1'b0, 1'b0};
    full_b  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("reset_a_gnt", 32'(gnt_a), 3);
    check("reset_a_push", 32'(push_a), 0);
    check("reset_b_gnt", 32'(gnt_b), 7);
    check("reset_b_push", 32'(push_b), 0);

    // Both masters to slave 0, never full: alternating grants.
    empty_a[0] = 1'b0;
    empty_a[1] = 1'b0;
    #1;
    check("alt_idle_gnt", 32'(gnt_a), 3);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("alt_gnt", 32'(gnt_a), 32'(k % 2));
      check("alt_push", 32'(push_a), 1);
    end

    // Both withdraw while master 1 holds the grant.
    empty_a[0] = 1'b1;
    empty_a[1] = 1'b1;
    #1;
    check("withdraw_push", 32'(push_a), 0);
    check("withdraw_gnt_hold", 32'(gnt_a), 1);
    tick();
    check("withdraw_idle_gnt", 32'(gnt_a), 3);

    // Master 1 alone, stalled on full for three granted cycles.
    empty_a[1] = 1'b0;
    full_a     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("full_gnt", 32'(gnt_a), 1);
      check("full_push", 32'(push_a), 1);
    end
    full_a = 1'b0;
    #1;
    check("unfull_push", 32'(push_a), 1);
    tick();
    check("bubble_gnt", 32'(gnt_a), 3);
    check("bubble_push", 32'(push_a), 0);
    tick();
    check("regrant_gnt", 32'(gnt_a), 1);
    empty_a[1] = 1'b1;
    tick();
    check("regrant_idle", 32'(gnt_a), 3);

    // Master 0 targets slave 1: never granted here.
    empty_a[0] = 1'b0;
    dest_a[0]  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("dest_gnt", 32'(gnt_a), 3);
      check("dest_push", 32'(push_a), 0);
    end

    // Master 0 granted, then empties before the transfer.
    dest_a[0] = 1'b0;
    tick();
    check("drop_gnt", 32'(gnt_a), 0);
    check("drop_push_before", 32'(push_a), 1);
    empty_a[0] = 1'b1;
    #1;
    check("drop_push_after", 32'(push_a), 0);
    tick();
    check("drop_idle_gnt", 32'(gnt_a), 3);
    // rr_ptr still points at master 1, so master 0 wins the tie.
    empty_a[0] = 1'b0;
    empty_a[1] = 1'b0;
    tick();
    check("rr_kept_gnt", 32'(gnt_a), 0);
    tick();
    check("rr_kept_next", 32'(gnt_a), 1);

    // Reset pulse while master 1 is granted.
    rst_n = 1'b0;
    tick();
    check("midreset_gnt", 32'(gnt_a), 3);
    check("midreset_push", 32'(push_a), 0);
    rst_n = 1'b1;
    tick();
    check("postreset_gnt", 32'(gnt_a), 0);
    empty_a[0] = 1'b1;
    empty_a[1] = 1'b1;
    tick();

    // Four masters: move rr_ptr to 2, then 0,2,3 request -> 3,0,2.
    empty_b[2] = 1'b0;
    tick();
    check("m4_first_gnt", 32'(gnt_b), 2);
    check("m4_first_push", 32'(push_b), 1);
    tick();
    check("m4_idle_gnt", 32'(gnt_b), 7);
    empty_b[0] = 1'b0;
    empty_b[3] = 1'b0;
    tick();
    check("m4_order_3", 32'(gnt_b), 3);
    check("m4_push_3", 32'(push_b), 1);
    tick();
    check("m4_order_0", 32'(gnt_b), 0);
    tick();
    check("m4_order_2", 32'(gnt_b), 2);
    check("m4_push_2", 32'(push_b), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
